// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: one requester's command/response channel into the BRAM port arbiter
interface bram_port_arbiter_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
  modport slave (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one no-change BRAM port between two requesters
module bram_port_arbiter #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic               clka,
  input  logic               rstb,
  bram_port_arbiter_if.slave req0,
  bram_port_arbiter_if.slave req1,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  output logic               ram_regce,
  output logic               ram_rst,
  input  logic [DATA_W-1:0]  ram_dout
);
  logic            last1;
  logic            grant0;
  logic            grant1;
  logic            acc;
  logic            sel_we;
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_id;
  // last1 = 1 means requester 1 was served last, so requester 0 wins the next tie
  always_comb begin
    grant0 = ~rstb & req0.valid & (~req1.valid | last1);
    grant1 = ~rstb & req1.valid & (~req0.valid | ~last1);
    acc    = grant0 | grant1;
    sel_we = grant1 ? req1.we : req0.we;
  end
  assign req0.ready = grant0;
  assign req1.ready = grant1;
  always_ff @(posedge clka) begin
    if (rstb) begin
      last1     <= 1'b1;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_regce <= 1'b0;
      tag_v     <= '0;
      tag_id    <= '0;
    end else begin
      if (acc) last1 <= grant1;
      ram_en    <= acc;
      ram_we    <= acc & sel_we;
      ram_regce <= 1'b1;
      if (acc) ram_addr <= grant1 ? req1.addr : req0.addr;
      if (acc) ram_din <= grant1 ? req1.wdata : req0.wdata;
      tag_v     <= {tag_v[RD_LAT-1:0], acc & ~sel_we};
      tag_id    <= {tag_id[RD_LAT-1:0], grant1};
    end
  end
  // the last tag stage lines up with ram_dout of the matching read
  assign req0.rsp_valid = tag_v[RD_LAT] & ~tag_id[RD_LAT];
  assign req1.rsp_valid = tag_v[RD_LAT] & tag_id[RD_LAT];
  assign req0.rsp_rdata = req0.rsp_valid ? ram_dout : '0;
  assign req1.rsp_rdata = req1.rsp_valid ? ram_dout : '0;
  assign ram_rst        = rstb;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of arbitration, issue timing, response routing and reset
module tb_bram_port_arbiter;
  localparam int DW = 18;
  localparam int AW = 10;
  logic clka = 1'b0;
  logic rstb = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clka = ~clka;
  bram_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) a0 ();
  bram_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
  bram_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  bram_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  logic a_en, a_we, a_regce, a_rst, b_en, b_we, b_regce, b_rst;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic [DW-1:0] a_d1 = '0;
  logic [DW-1:0] a_d2 = '0;
  logic [DW-1:0] b_d1 = '0;
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut_a (
    .clka(clka), .rstb(rstb), .req0(a0), .req1(a1),
    .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_din(a_din),
    .ram_regce(a_regce), .ram_rst(a_rst), .ram_dout(a_d2));
  bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut_b (
    .clka(clka), .rstb(rstb), .req0(b0), .req1(b1),
    .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_din(b_din),
    .ram_regce(b_regce), .ram_rst(b_rst), .ram_dout(b_d1));
  // high-performance no-change RAM: output register with regce/rst
  always @(posedge clka) begin
    if (a_en) begin
      if (a_we) mem_a[a_addr] <= a_din;
      else a_d1 <= mem_a[a_addr];
    end
    if (a_rst) a_d2 <= '0;
    else if (a_regce) a_d2 <= a_d1;
  end
  // low-latency no-change RAM
  always @(posedge clka)
    if (b_en) begin
      if (b_we) mem_b[b_addr] <= b_din;
      else b_d1 <= mem_b[b_addr];
    end

  task step;
    @(posedge clka);
    #1;
  endtask

  task settle;
    #3;
  endtask

  task set_a(input logic v0, input logic we0, input logic [AW-1:0] ad0, input logic [DW-1:0] wd0,
             input logic v1, input logic [AW-1:0] ad1);
    a0.valid = v0; a0.we = we0; a0.addr = ad0; a0.wdata = wd0;
    a1.valid = v1; a1.we = 1'b0; a1.addr = ad1; a1.wdata = '0;
  endtask

  task preload;
    for (int i = 0; i < 4; i++) begin
      set_a(i < 2, 1'b1, AW'(32'h20 + i), DW'(32'h100 + i), 1'b0, '0);
      b0.valid = 1'b1; b0.we = 1'b1; b0.addr = AW'(i + 1); b0.wdata = DW'(32'h11 * (i + 1));
      step;
    end
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    b0.valid = 1'b0; b0.we = 1'b0;
    step;
    step;
  endtask

  task test_reset;
    rstb = 1'b1;
    set_a(1'b1, 1'b0, 10'h20, '0, 1'b1, 10'h21);
    b0.valid = 1'b1;
    settle;
    checks++;
    if ({a0.ready, a1.ready, b0.ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b want 000", {a0.ready, a1.ready, b0.ready});
    end
    step;
    settle;
    checks++;
    if ({a_en, a_we, a_regce, a0.rsp_valid, a1.rsp_valid, b_en, b_regce, b0.rsp_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {a_en, a_we, a_regce, a0.rsp_valid, a1.rsp_valid, b_en, b_regce, b0.rsp_valid});
    end
    checks++;
    if ({a_addr, a_din} !== '0) begin
      errors++; $display("FAIL reset_bus got addr %h din %h want 0 0", a_addr, a_din);
    end
    checks++;
    if ({a_rst, b_rst} !== 2'b11) begin
      errors++; $display("FAIL reset_ram_rst got %b want 11", {a_rst, b_rst});
    end
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    b0.valid = 1'b0;
    rstb = 1'b0;
    step;
  endtask

  task test_round_robin;
    int j;
    logic [1:0] er, ev;
    for (int k = 0; k < 10; k++) begin
      set_a(k < 6, 1'b0, 10'h20, '0, k < 6, 10'h21);
      settle;
      er = (k < 6) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      j = k - 3;
      ev = (j >= 0 && j < 6) ? ((j % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({a0.ready, a1.ready} !== er) begin
        errors++; $display("FAIL rr_ready k=%0d got %b want %b", k, {a0.ready, a1.ready}, er);
      end
      checks++;
      if ({a0.rsp_valid, a1.rsp_valid} !== ev) begin
        errors++; $display("FAIL rr_rsp_valid k=%0d got %b want %b", k, {a0.rsp_valid, a1.rsp_valid}, ev);
      end
      checks++;
      if (a0.rsp_rdata !== (ev[1] ? 18'h100 : 18'h0) || a1.rsp_rdata !== (ev[0] ? 18'h101 : 18'h0)) begin
        errors++; $display("FAIL rr_rsp_data k=%0d got %h/%h", k, a0.rsp_rdata, a1.rsp_rdata);
      end
      if (k >= 1 && k <= 6) begin
        checks++;
        if ({a_en, a_we, a_addr} !== {2'b10, AW'(32'h20 + (k - 1) % 2)}) begin
          errors++; $display("FAIL rr_issue k=%0d got en%b we%b addr %h", k, a_en, a_we, a_addr);
        end
      end
      step;
    end
  endtask

  task test_single_then_both;
    logic [1:0] er;
    for (int k = 0; k < 6; k++) begin
      set_a(k >= 3 && k < 5, 1'b0, 10'h20, '0, k < 5, 10'h21);
      settle;
      er = (k < 3) ? 2'b01 : (k == 3) ? 2'b10 : (k == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({a0.ready, a1.ready} !== er) begin
        errors++; $display("FAIL single_both k=%0d got %b want %b", k, {a0.ready, a1.ready}, er);
      end
      step;
    end
    for (int k = 0; k < 4; k++) step;
  endtask

  task test_write_read;
    set_a(1'b1, 1'b1, 10'h05, 18'h2A5, 1'b0, '0);
    settle;
    checks++;
    if (a0.ready !== 1'b1) begin
      errors++; $display("FAIL wr_accept got %b want 1", a0.ready);
    end
    step;
    set_a(1'b1, 1'b0, 10'h05, '0, 1'b0, '0);
    settle;
    checks++;
    if ({a0.ready, a_en, a_we, a_addr, a_din} !== {3'b111, 10'h05, 18'h2A5}) begin
      errors++; $display("FAIL wr_issue got rdy%b en%b we%b addr %h din %h", a0.ready, a_en, a_we, a_addr, a_din);
    end
    step;
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 2; k < 6; k++) begin
      settle;
      checks++;
      if ({a0.rsp_valid, a1.rsp_valid} !== ((k == 4) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL wr_rd_rsp_valid cyc=%0d got %b", k, {a0.rsp_valid, a1.rsp_valid});
      end
      if (k == 2) begin
        checks++;
        if ({a_en, a_we, a_addr} !== {2'b10, 10'h05}) begin
          errors++; $display("FAIL rd_issue got en%b we%b addr %h want 1 0 005", a_en, a_we, a_addr);
        end
      end
      if (k == 4) begin
        checks++;
        if (a0.rsp_rdata !== 18'h2A5) begin
          errors++; $display("FAIL wr_rd_data got %h want 2a5", a0.rsp_rdata);
        end
      end
      step;
    end
  endtask

  task test_reset_in_flight;
    set_a(1'b1, 1'b0, 10'h20, '0, 1'b1, 10'h21);
    settle;
    checks++;
    if ({a0.ready, a1.ready} !== 2'b01) begin
      errors++; $display("FAIL mid_pre_ptr got %b want 01", {a0.ready, a1.ready});
    end
    step;
    step;
    rstb = 1'b1;
    settle;
    checks++;
    if ({a0.ready, a1.ready} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ready got %b want 00", {a0.ready, a1.ready});
    end
    step;
    rstb = 1'b0;
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    settle;
    checks++;
    if ({a_en, a_we, a_regce, a0.rsp_valid, a1.rsp_valid, a_addr, a_din} !== '0) begin
      errors++; $display("FAIL mid_rst_outputs got en%b we%b regce%b rsp%b%b addr %h din %h",
                         a_en, a_we, a_regce, a0.rsp_valid, a1.rsp_valid, a_addr, a_din);
    end
    step;
    set_a(1'b1, 1'b0, 10'h20, '0, 1'b1, 10'h21);
    settle;
    checks++;
    if ({a0.ready, a1.ready, a0.rsp_valid, a1.rsp_valid} !== 4'b1000) begin
      errors++; $display("FAIL mid_post_ptr got rdy %b rsp %b want 10 00", {a0.ready, a1.ready}, {a0.rsp_valid, a1.rsp_valid});
    end
    step;
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      settle;
      checks++;
      if ({a0.rsp_valid, a1.rsp_valid, a_regce} !== 3'b001) begin
        errors++; $display("FAIL mid_no_rsp k=%0d got rsp %b regce %b", k, {a0.rsp_valid, a1.rsp_valid}, a_regce);
      end
      step;
    end
    for (int k = 0; k < 3; k++) step;
  endtask

  task test_idle;
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      settle;
      checks++;
      if ({a_en, a_we} !== 2'b00) begin
        errors++; $display("FAIL idle k=%0d got en%b we%b want 0 0", k, a_en, a_we);
      end
      step;
    end
    set_a(1'b1, 1'b0, 10'h05, '0, 1'b0, '0);
    step;
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step;
    step;
    settle;
    checks++;
    if ({a0.rsp_valid, a0.rsp_rdata} !== {1'b1, 18'h2A5}) begin
      errors++; $display("FAIL idle_readback got v%b %h want 1 2a5", a0.rsp_valid, a0.rsp_rdata);
    end
    step;
  endtask

  task test_back_to_back_lat1;
    int j;
    logic ev;
    for (int k = 0; k < 7; k++) begin
      b0.valid = k < 4; b0.we = 1'b0; b0.addr = AW'(k + 1); b0.wdata = '0;
      settle;
      j = k - 2;
      ev = j >= 0 && j < 4;
      checks++;
      if (b0.ready !== (k < 4)) begin
        errors++; $display("FAIL b2b_ready k=%0d got %b", k, b0.ready);
      end
      checks++;
      if ({b0.rsp_valid, b1.rsp_valid} !== {ev, 1'b0} || b0.rsp_rdata !== (ev ? DW'(32'h11 * (j + 1)) : DW'(0))) begin
        errors++; $display("FAIL b2b_rsp k=%0d got v%b%b data %h", k, b0.rsp_valid, b1.rsp_valid, b0.rsp_rdata);
      end
      step;
    end
    b0.valid = 1'b0;
  endtask

  initial begin
    set_a(1'b0, 1'b0, '0, '0, 1'b0, '0);
    b0.valid = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
    b1.valid = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
    step;
    rstb = 1'b0;
    preload;
    test_reset;
    test_round_robin;
    test_single_then_both;
    test_write_read;
    test_reset_in_flight;
    test_idle;
    test_back_to_back_lat1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
